// File: rtl/axi_chan_pkg.sv
// Shared channel definitions for the receive and transmit channel logic.
package axi_chan_pkg;

   // Channel handshake state, common to both channel directions.
   typedef enum logic [1:0] {
      RST     = 2'd0,
      EMPTY   = 2'd1,
      PARTIAL = 2'd2,
      FULL    = 2'd3
   } chan_state_t;

   // True when a channel in this state can take a beat from the transmitter.
   function automatic logic chan_can_accept(input chan_state_t st);
      return (st == EMPTY) || (st == PARTIAL);
   endfunction

endpackage : axi_chan_pkg

// File: rtl/rx_buffer.sv
// Receive storage: circular array with a tail write port and a head read port.
module rx_buffer
   import axi_chan_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   // Pointer advance; DEPTH is a power of two so the natural wrap is modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers; reset returns both to slot zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule : rx_buffer

// File: rtl/rx_channel.sv
// Receive channel: VALID/READY bus handshake into a buffer drained by a local consumer.
module rx_channel
   import axi_chan_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         VALID,
   input  logic [WIDTH-1:0]             xDATA,
   output logic                         READY,
   output logic [WIDTH-1:0]             rx_data,
   output logic                         rx_valid,
   input  logic                         rx_en,
   output logic [$clog2(DEPTH+1)-1:0]   rx_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   chan_state_t       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              push_c;
   logic              pop_c;

   // Handshakes use only registered READY/rx_valid; reset suppresses both.
   assign push_c = VALID && ready_q && !ARESET;
   assign pop_c  = valid_q && rx_en && !ARESET;

   // Next state, occupancy and the registered READY/rx_valid they imply.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         RST: begin
            state_d = EMPTY;
            count_d = '0;
         end
         EMPTY: begin
            if (push_c) begin
               state_d = PARTIAL;
               count_d = CNT_W'(1);
            end
         end
         PARTIAL: begin
            if (push_c && !pop_c) begin
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(DEPTH - 1)) state_d = FULL;
            end else if (pop_c && !push_c) begin
               count_d = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop_c) begin
               state_d = PARTIAL;
               count_d = CNT_W'(DEPTH - 1);
            end
         end
         default: begin
            state_d = RST;
            count_d = '0;
         end
      endcase
      if (ARESET) begin
         state_d = RST;
         count_d = '0;
      end
      ready_d = chan_can_accept(state_d);
      valid_d = (count_d != '0);
   end

   // State, occupancy and handshake output registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= RST;
         count_q <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   rx_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_rx_buffer (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (push_c),
      .wr_data (xDATA),
      .rd_en   (pop_c),
      .rd_data (rx_data)
   );

   assign READY    = ready_q;
   assign rx_valid = valid_q;
   assign rx_count = count_q;

endmodule : rx_channel

// File: tb/tb_rx_channel.sv
// Bench for rx_channel: directed scenarios plus random traffic against a queue model.
module tb_rx_channel;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             ACLK = 1'b0;
   logic             ARESET = 1'b1;
   logic             VALID = 1'b0;
   logic [WIDTH-1:0] xDATA = '0;
   logic             READY;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_en = 1'b0;
   logic [CNT_W-1:0] rx_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: arrival-ordered queue plus a "just reset" flag.
   logic [WIDTH-1:0] mq [$];
   bit               m_rst = 1'b1;

   rx_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .VALID    (VALID),
      .xDATA    (xDATA),
      .READY    (READY),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_en    (rx_en),
      .rx_count (rx_count)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive at negedge, step the model, compare #1 after the edge.
   task automatic tick(input bit rst, input bit v, input logic [WIDTH-1:0] d, input bit en);
      bit m_ready, push, pop;
      @(negedge ACLK);
      ARESET = rst; VALID = v; xDATA = d; rx_en = en;
      m_ready = !m_rst && (mq.size() < DEPTH);
      push = v && m_ready;
      pop  = en && (mq.size() != 0);
      @(posedge ACLK);
      if (rst) begin
         mq.delete();
         m_rst = 1'b1;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(d);
         m_rst = 1'b0;
      end
      #1;
      check("ready", 32'(READY), 32'(!m_rst && (mq.size() < DEPTH)));
      check("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      check("rx_count", 32'(rx_count), 32'(mq.size()));
      if (mq.size() != 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
   endtask

   initial begin
      logic [WIDTH-1:0] drain [4];
      drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44; drain[3] = 8'h55;

      // Reset release: READY low on the reset edge and one after, then high.
      tick(1, 0, 8'h00, 0);
      check("rst_ready", 32'(READY), 32'd0);
      check("rst_count", 32'(rx_count), 32'd0);
      tick(0, 0, 8'h00, 0);
      tick(0, 0, 8'h00, 0);
      check("release_ready", 32'(READY), 32'd1);
      check("release_valid", 32'(rx_valid), 32'd0);

      // Fill to full, then a held 5th beat must not be taken.
      tick(0, 1, 8'h11, 0); check("fill1", 32'(rx_count), 32'd1);
      tick(0, 1, 8'h22, 0); check("fill2", 32'(rx_count), 32'd2);
      tick(0, 1, 8'h33, 0); check("fill3", 32'(rx_count), 32'd3);
      tick(0, 1, 8'h44, 0); check("fill4", 32'(rx_count), 32'd4);
      check("full_ready", 32'(READY), 32'd0);
      tick(0, 1, 8'h55, 0); check("held_count", 32'(rx_count), 32'd4);
      check("held_head", 32'(rx_data), 32'h11);

      // One pop from full frees a slot; the held beat enters next edge.
      tick(0, 1, 8'h55, 1);
      check("pop_ready", 32'(READY), 32'd1);
      check("pop_count", 32'(rx_count), 32'd3);
      tick(0, 1, 8'h55, 0);
      check("accept55", 32'(rx_count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 32'(rx_data), 32'(drain[i]));
         tick(0, 0, 8'h00, 1);
      end
      check("drained", 32'(rx_count), 32'd0);

      // Simultaneous push and pop at occupancy one.
      tick(1, 0, 8'h00, 0);
      tick(0, 0, 8'h00, 0);
      tick(0, 1, 8'hA0, 0);
      tick(0, 1, 8'hB0, 1);
      check("pp_count", 32'(rx_count), 32'd1);
      check("pp_data", 32'(rx_data), 32'hB0);

      // Streaming with the consumer always ready: pointers wrap, occupancy stays <= 1.
      tick(1, 0, 8'h00, 0);
      tick(0, 0, 8'h00, 0);
      for (int i = 0; i < 10; i++) begin
         tick(0, 1, WIDTH'(i), 1);
         check("stream_data", 32'(rx_data), 32'(i));
         check("stream_le1", 32'(rx_count <= CNT_W'(1)), 32'd1);
      end
      tick(0, 0, 8'h00, 1);
      check("stream_empty", 32'(rx_count), 32'd0);

      // Reset mid-operation discards contents and the concurrent beat.
      tick(0, 1, 8'h01, 0);
      tick(0, 1, 8'h02, 0);
      tick(0, 1, 8'h03, 0);
      check("pre_rst_count", 32'(rx_count), 32'd3);
      tick(1, 1, 8'h77, 0);
      check("mid_rst_count", 32'(rx_count), 32'd0);
      check("mid_rst_valid", 32'(rx_valid), 32'd0);
      check("mid_rst_ready", 32'(READY), 32'd0);
      tick(0, 0, 8'h00, 0);
      check("no_ghost", 32'(rx_count), 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              WIDTH'($urandom), ($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1) & ($urandom_range(0, 1) == 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rx_channel

// File: doc/rx_channel.md
RX_CHANNEL -- requirements
Module: rx_channel

Interface
REQ-001 Parameter WIDTH, default 8, data width of the channel payload.
REQ-002 Parameter DEPTH, default 4, receive buffer entries; power of two, >= 2.
REQ-003 ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 ARESET  input  1  synchronous, active-high reset, sampled on rising ACLK.
REQ-005 VALID  input  1  transmitter asserts when xDATA holds a valid beat.
REQ-006 xDATA  input  WIDTH  beat payload from transmitter.
REQ-007 READY  output  1  receiver can accept a beat this cycle.
REQ-008 rx_data  output  WIDTH  oldest buffered beat, presented to the local consumer.
REQ-009 rx_valid  output  1  rx_data holds a valid buffered beat.
REQ-010 rx_en  input  1  consumer pops the head beat when rx_valid is also high.
REQ-011 rx_count  output  $clog2(DEPTH+1)  current buffer occupancy, 0..DEPTH.

Function
REQ-012 Bus transfer (push) occurs on a rising ACLK edge where VALID && READY; xDATA is written at the tail.
REQ-013 Consumer pop occurs on a rising ACLK edge where rx_valid && rx_en; the head advances.
REQ-014 READY is decoded from registered state only; no combinational path from VALID, xDATA or rx_en to READY.
REQ-015 READY is not gated by VALID: it is high whenever state is EMPTY or PARTIAL, even with VALID low.
REQ-016 rx_valid = (rx_count != 0); rx_data = head entry; rx_data is don't-care when rx_valid is low.
REQ-017 State machine states: RST, EMPTY, PARTIAL, FULL.
REQ-018 RST: READY=0 and rx_valid=0; the next state is always EMPTY.
REQ-019 EMPTY: push only -> PARTIAL, or FULL if DEPTH==1 (DEPTH==1 is disallowed, so PARTIAL); no push -> EMPTY; a pop is impossible (rx_valid=0).
REQ-020 PARTIAL: push without pop -> count+1, FULL at DEPTH; pop without push -> count-1, EMPTY at 0; push and pop together -> count unchanged, state unchanged.
REQ-021 FULL: READY=0, so no push; pop -> PARTIAL with count DEPTH-1; no pop -> FULL.
REQ-022 Simultaneous push and pop with count==1: the head pops, the new beat is written, and count stays 1.
REQ-023 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-024 Beats leave in exact arrival order; none is dropped or duplicated.
REQ-025 First-word latency: a beat pushed at edge N is visible on rx_data with rx_valid=1 after edge N (same cycle as the count update).
REQ-026 VALID held high while READY is low causes no state change; the transmitter's held beat is accepted on the first edge where READY=1.

Reset
REQ-027 While ARESET=1 at a rising edge: state<=RST, pointers<=0, count<=0; buffer contents are not cleared.
REQ-028 Outputs after the reset edge: READY=0, rx_valid=0, rx_count=0.
REQ-029 Reset asserted mid-operation discards all buffered beats; any concurrent push or pop on that edge is ignored.
REQ-030 READY first rises one cycle after ARESET deasserts (RST -> EMPTY).

Structure
REQ-031 Shared package axi_chan_pkg holds chan_state_t {RST, EMPTY, PARTIAL, FULL}, shared with the transmit-side channel logic.
REQ-032 Storage array with write port and read pointer is sub-module rx_buffer (parameters WIDTH, DEPTH); the state machine, count and handshake decode stay in rx_channel.
REQ-033 No latches: every combinational output is assigned on every path.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset release, VALID=0 -> cycle 1 READY=0; cycle 2 READY=1, rx_valid=0, rx_count=0.
REQ-035 Push 0x11,0x22,0x33,0x44 back-to-back with rx_en=0 -> rx_count 1,2,3,4; READY=0 after the 4th push; 5th beat 0x55 held on VALID is not accepted.
REQ-036 From full, rx_en=1 for one cycle -> pops 0x11, READY=1, 0x55 accepted next edge; then drain order is 0x22,0x33,0x44,0x55.
REQ-037 Count=1 (0xA0), VALID=1 with 0xB0 and rx_en=1 on the same edge -> rx_count stays 1, rx_data=0xB0.
REQ-038 Stream 10 beats 0x00..0x09 with rx_en=1 continuously -> pointers wrap, output order 0x00..0x09, rx_count never exceeds 1.
REQ-039 ARESET=1 with count=3 and VALID=1 -> next cycle rx_count=0, rx_valid=0, READY=0; the pending beat is not stored.
